pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order ALU/memory pipeline.
- Keeps its own scoreboard of in-flight instructions, one entry for EX (S[0]) and one for each later stage S[1..NUM_FWD].
- From that scoreboard it generates EX operand forwarding selects, load-use stalls and redirect flushes, and runs a halt-drain state machine.
- Replaces the fixed two-stage, no-stall forwarding logic with configurable depth, load latency and register-address width.

Parameters:
- REG_AW, 3: register address width.
- NUM_FWD, 2: number of stages after EX that can forward (1=MEM, 2=WB, ...). Must be >=1.
- LOAD_STAGE, 1: first post-EX stage whose load data is forwardable. Must satisfy 1 <= LOAD_STAGE <= NUM_FWD.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  instruction present in ID.
- id_src_a  in  REG_AW  ID source A (RqRd).
- id_src_b  in  REG_AW  ID source B (Rs).
- id_use_a  in  1  source A is read.
- id_use_b  in  1  source B is read.
- id_dst  in  REG_AW  ID destination register.
- id_wr_en  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- id_halt  in  1  ID instruction is halt.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- stall_f  out  1  hold the PC and the IF/ID register.
- flush_if_id  out  1  squash IF/ID (insert nop).
- flush_id_ex  out  1  insert a bubble into ID/EX.
- fwd_sel_a  out  $clog2(NUM_FWD+1)  EX operand A source: 0=register-file value, k=stage S[k] result.
- fwd_sel_b  out  $clog2(NUM_FWD+1)  same encoding for operand B.
- fetch_halt  out  1  stop fetching (registered).
- halted  out  1  pipeline drained after halt (registered, sticky).

Behaviour:
- Scoreboard entry fields: {valid, dst, wr_en, mem_read, halt, src_a, src_b, use_a, use_b}.
- Reset (rst low, asynchronous): all entries invalid, state RUN, fetch_halt=0, halted=0. All combinational outputs then evaluate to 0.
- Every edge: S[k] <= S[k-1] for k=1..NUM_FWD.
- Every edge: S[0] <= ID fields if accept, else a bubble (valid=0).
- accept = id_valid & ~load_use & ~ex_redirect & (state==RUN).
- Load-use hazard, combinational:
  - load_use = 1 when, for some j in 0..LOAD_STAGE-2, S[j].valid & S[j].wr_en & S[j].mem_read is true and S[j].dst equals a used ID source (id_use_a/id_src_a or id_use_b/id_src_b).
  - With LOAD_STAGE=1 this can never assert.
- Combinational outputs:
  - stall_f = (load_use & ~ex_redirect) | (state!=RUN).
  - flush_if_id = ex_redirect & (state==RUN).
  - flush_id_ex = ~accept & id_valid.
- Forwarding, combinational, from S[0] sources:
  - fwd_sel_a = smallest k in 1..NUM_FWD with S[k].valid & S[k].wr_en & S[k].dst==S[0].src_a & S[0].use_a; 0 if none. The youngest producer wins.
  - fwd_sel_b is computed the same way.
  - Forwarding is only evaluated when S[0].valid; otherwise both selects are 0.
  - A load at k<LOAD_STAGE that matches is an error. The bench checks it never occurs; the stall guarantees this.
- Priority when events coincide:
  - ex_redirect beats load_use: no stall, both flushes asserted, S[0] becomes a bubble.
  - A halt in ID during a redirect is squashed and not accepted.
- Halt FSM, states RUN / DRAIN / HALTED:
  - RUN -> DRAIN on an edge with accept & id_halt. At that edge fetch_halt <= 1 and drain counter <= NUM_FWD.
  - DRAIN: no instruction is accepted; the counter decrements each edge.
  - DRAIN -> HALTED on the edge where the counter is 1. halted <= 1 at that edge, when the halt entry occupies S[NUM_FWD].
  - HALTED is sticky until reset.
  - ex_redirect is ignored in DRAIN and HALTED.
- Reset mid-DRAIN returns to RUN with all entries cleared.

Test Plan:
1. Defaults; I0 add r3 then I1 reads r3 as src_a -> in I1's EX cycle fwd_sel_a=1, fwd_sel_b=0, stall_f never 1.
2. Add r3, nop, reader of r3 as src_b -> fwd_sel_b=2. With r5 written by two consecutive instructions ahead of the reader -> fwd_sel=1 (youngest wins).
3. LOAD_STAGE=2: load r2 then add reading r2 -> stall_f=1 and flush_id_ex=1 for exactly one cycle, then fwd_sel_b=2 in the add's EX cycle. Same sequence with LOAD_STAGE=1 -> no stall, fwd_sel_b=1.
4. ex_redirect=1 in the same cycle as a load-use stall -> stall_f=0, flush_if_id=1, flush_id_ex=1, next S[0] bubble, fwd_sel=0.
5. Halt accepted at edge t (NUM_FWD=2) -> fetch_halt=1 from t, halted=1 from t+2, stall_f=1 thereafter, and following ID instructions are never forwarded.
6. rst low asynchronously mid-DRAIN -> fetch_halt=0, halted=0, fwd_sel=0 immediately; after release, normal forwarding resumes.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: an internal scoreboard of EX..S[NUM_FWD] drives
// operand forwarding selects, load-use stalls, redirect flushes and a halt drain.

module phc_stage_cmp #(
  parameter int REG_AW = 3
) (
  input  logic              valid,
  input  logic              wr_en,
  input  logic              mem_read,
  input  logic [REG_AW-1:0] dst,
  input  logic [REG_AW-1:0] ex_src_a,
  input  logic [REG_AW-1:0] ex_src_b,
  input  logic              ex_use_a,
  input  logic              ex_use_b,
  input  logic [REG_AW-1:0] id_src_a,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic              ld_hit
);
  logic prod;

  assign prod      = valid & wr_en;
  assign fwd_hit_a = prod & ex_use_a & (dst == ex_src_a);
  assign fwd_hit_b = prod & ex_use_b & (dst == ex_src_b);
  assign ld_hit    = prod & mem_read &
                     ((id_use_a & (dst == id_src_a)) | (id_use_b & (dst == id_src_b)));
endmodule

module pipe_hazard_ctrl #(
  parameter int REG_AW     = 3,
  parameter int NUM_FWD    = 2,
  parameter int LOAD_STAGE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_AW-1:0]            id_src_a,
  input  logic [REG_AW-1:0]            id_src_b,
  input  logic                         id_use_a,
  input  logic                         id_use_b,
  input  logic [REG_AW-1:0]            id_dst,
  input  logic                         id_wr_en,
  input  logic                         id_mem_read,
  input  logic                         id_halt,
  input  logic                         ex_redirect,
  output logic                         stall_f,
  output logic                         flush_if_id,
  output logic                         flush_id_ex,
  output logic [$clog2(NUM_FWD+1)-1:0] fwd_sel_a,
  output logic [$clog2(NUM_FWD+1)-1:0] fwd_sel_b,
  output logic                         fetch_halt,
  output logic                         halted
);
  localparam int SEL_W = $clog2(NUM_FWD+1);
  localparam logic [NUM_FWD:0] FWD_MASK = {{NUM_FWD{1'b1}}, 1'b0};
  // Only loads still short of LOAD_STAGE can cause a load-use stall.
  localparam logic [NUM_FWD:0] LD_MASK  = (NUM_FWD+1)'((1 << (LOAD_STAGE-1)) - 1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              wr_en;
    logic              mem_read;
  } prod_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  prod_t             prod_q [NUM_FWD+1];
  prod_t             prod_d [NUM_FWD+1];
  logic [REG_AW-1:0] ex_src_a_q, ex_src_a_d, ex_src_b_q, ex_src_b_d;
  logic              ex_use_a_q, ex_use_a_d, ex_use_b_q, ex_use_b_d;
  state_t            state_q, state_d;
  logic [SEL_W-1:0]  cnt_q, cnt_d;
  logic              fetch_halt_q, fetch_halt_d;
  logic              halted_q, halted_d;

  logic [NUM_FWD:0]  hit_a, hit_b, ld_hit;
  logic [NUM_FWD:0]  hit_a_m, hit_b_m;
  logic              load_use, running, accept;

  for (genvar g = 0; g <= NUM_FWD; g++) begin : g_stage
    phc_stage_cmp #(.REG_AW(REG_AW)) u_cmp (
      .valid     (prod_q[g].valid),
      .wr_en     (prod_q[g].wr_en),
      .mem_read  (prod_q[g].mem_read),
      .dst       (prod_q[g].dst),
      .ex_src_a  (ex_src_a_q),
      .ex_src_b  (ex_src_b_q),
      .ex_use_a  (ex_use_a_q),
      .ex_use_b  (ex_use_b_q),
      .id_src_a  (id_src_a),
      .id_src_b  (id_src_b),
      .id_use_a  (id_use_a),
      .id_use_b  (id_use_b),
      .fwd_hit_a (hit_a[g]),
      .fwd_hit_b (hit_b[g]),
      .ld_hit    (ld_hit[g])
    );
  end

  assign load_use    = |(ld_hit & LD_MASK);
  assign running     = (state_q == RUN);
  assign accept      = id_valid & ~load_use & ~ex_redirect & running;

  assign stall_f     = (load_use & ~ex_redirect) | ~running;
  assign flush_if_id = ex_redirect & running;
  assign flush_id_ex = ~accept & id_valid;
  assign fetch_halt  = fetch_halt_q;
  assign halted      = halted_q;

  assign hit_a_m = prod_q[0].valid ? (hit_a & FWD_MASK) : '0;
  assign hit_b_m = prod_q[0].valid ? (hit_b & FWD_MASK) : '0;

  // Scan oldest to youngest so the nearest producer overrides.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    for (int k = NUM_FWD; k >= 0; k--) begin
      if (hit_a_m[k]) fwd_sel_a = SEL_W'(k);
      if (hit_b_m[k]) fwd_sel_b = SEL_W'(k);
    end
  end

  always_comb begin
    prod_d[0]  = '0;
    ex_src_a_d = '0;
    ex_src_b_d = '0;
    ex_use_a_d = 1'b0;
    ex_use_b_d = 1'b0;
    if (accept) begin
      prod_d[0]  = '{valid: 1'b1, dst: id_dst, wr_en: id_wr_en, mem_read: id_mem_read};
      ex_src_a_d = id_src_a;
      ex_src_b_d = id_src_b;
      ex_use_a_d = id_use_a;
      ex_use_b_d = id_use_b;
    end
    for (int k = 1; k <= NUM_FWD; k++) prod_d[k] = prod_q[k-1];
  end

  // Drain counter times the halt's walk from S[0] to S[NUM_FWD].
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fetch_halt_d = fetch_halt_q;
    halted_d     = halted_q;
    case (state_q)
      RUN: begin
        if (accept & id_halt) begin
          state_d      = DRAIN;
          cnt_d        = SEL_W'(NUM_FWD);
          fetch_halt_d = 1'b1;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SEL_W'(1)) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= NUM_FWD; k++) prod_q[k] <= '0;
      ex_src_a_q   <= '0;
      ex_src_b_q   <= '0;
      ex_use_a_q   <= 1'b0;
      ex_use_b_q   <= 1'b0;
      state_q      <= RUN;
      cnt_q        <= '0;
      fetch_halt_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      for (int k = 0; k <= NUM_FWD; k++) prod_q[k] <= prod_d[k];
      ex_src_a_q   <= ex_src_a_d;
      ex_src_b_q   <= ex_src_b_d;
      ex_use_a_q   <= ex_use_a_d;
      ex_use_b_q   <= ex_use_b_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fetch_halt_q <= fetch_halt_d;
      halted_q     <= halted_d;
    end
  end
endmodule
